// File: rtl/saber_pkg.sv
// Shared types and helpers for the Saber negacyclic MAC array.
// SABER_LIGHTSABER_EN widens the supported secret magnitude range from 0..4 to 0..5.
package saber_pkg;

    localparam int Q_W    = 13;
    localparam int LANE_W = 16;

`ifdef SABER_LIGHTSABER_EN
    localparam int MAX_MAG = 5;
`else
    localparam int MAX_MAG = 4;
`endif

    // Sign-magnitude secret coefficient: value = (sign ? -mag : mag).
    typedef struct packed {
        logic       sign;
        logic [2:0] mag;
    } sec_coef_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Zero must stay 4'b0000, so the sign only flips for a non-zero magnitude.
    function automatic sec_coef_t sec_neg(input sec_coef_t c);
        sec_coef_t r;
        r = c;
        if (c.mag != 3'd0) r.sign = ~c.sign;
        return r;
    endfunction

    function automatic sec_coef_t sec_canon(input logic [3:0] d);
        sec_coef_t r;
        r = sec_coef_t'(d);
        if (r.mag == 3'd0) r.sign = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/saber_mac_lane.sv
// One MAC lane: selects the registered multiple of a by the tap magnitude and
// adds or subtracts it from a 13-bit accumulator.
module saber_mac_lane
    import saber_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      en,
    input  logic [MAX_MAG:1][Q_W-1:0] ax_mul,
    input  sec_coef_t                 tap,
    input  logic                      sneg,
    output logic [Q_W-1:0]            acc,
    output logic                      bad
);

    logic [Q_W-1:0] prod;
    logic [Q_W-1:0] acc_next;

    always_comb begin
        prod = '0;
        bad  = 1'b0;
        case (tap.mag)
            3'd0: prod = '0;
            3'd1: prod = ax_mul[1];
            3'd2: prod = ax_mul[2];
            3'd3: prod = ax_mul[3];
            3'd4: prod = ax_mul[4];
`ifdef SABER_LIGHTSABER_EN
            3'd5: prod = ax_mul[5];
`endif
            default: bad = 1'b1;
        endcase
        // sneg is set on the run after a full rotation, when sreg holds -s.
        acc_next = (tap.sign ^ sneg) ? acc - prod : acc + prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/saber_mac_array.sv
// Sequential negacyclic MAC array: rotating secret register, streamed public
// coefficients, NUM_MAC accumulating lanes. Optional macro: SABER_LIGHTSABER_EN.
module saber_mac_array
    import saber_pkg::*;
#(
    parameter int NUM_MAC = 8,
    parameter int N       = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [3:0]                s_data,
    output logic                      s_ready,
    input  logic                      start,
    input  logic                      acc_keep,
    input  logic                      a_valid,
    input  logic [Q_W-1:0]            a_data,
    output logic                      a_ready,
    output logic [NUM_MAC*LANE_W-1:0] result,
    output logic                      result_valid,
    output logic                      busy,
    output logic                      err,
    output state_t                    dbg_state
);

    localparam int               CNT_W     = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(N);
    localparam state_t           LOAD_DEST = (N == 1) ? ST_READY : ST_LOAD;

    state_t         state;
    state_t         state_next;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] a_cnt;
    logic           sneg;
    sec_coef_t      sreg [N];

    logic start_accept;
    logic load_entry;
    logic s_accept;
    logic a_accept;
    logic lane_clear;

    logic                      s1_valid;
    logic                      s1_sneg;
    logic [MAX_MAG:1][Q_W-1:0] ax_next;
    logic [MAX_MAG:1][Q_W-1:0] ax_q;
    sec_coef_t                 tap_q [NUM_MAC];

    logic [Q_W-1:0]     lane_acc [NUM_MAC];
    logic [NUM_MAC-1:0] lane_bad;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid may drop at any time and no state moves without a transfer.
    always_comb begin
        start_accept = start && (state == ST_READY || state == ST_DONE);
        load_entry   = s_valid && !start_accept && (state == ST_IDLE || state == ST_DONE);
        s_accept     = load_entry || (s_valid && state == ST_LOAD);
        s_ready      = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DONE);
        a_ready      = (state == ST_RUN) && (a_cnt != FULL_CNT);
        a_accept     = a_valid && a_ready;
        lane_clear   = start_accept && !acc_keep;
        result_valid = (state == ST_DONE);
        busy         = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_DRAIN);
        dbg_state    = state;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_accept) state_next = ST_RUN;
                else if (load_entry) state_next = LOAD_DEST;
            end
            ST_LOAD:  if (s_accept && load_cnt == LAST_IDX) state_next = ST_READY;
            ST_READY: if (start_accept) state_next = ST_RUN;
            ST_RUN:   if (a_accept && a_cnt == LAST_IDX) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            load_cnt <= '0;
            a_cnt    <= '0;
            sneg     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            if (load_entry) begin
                load_cnt <= CNT_W'(1);
                sneg     <= 1'b0;
                err      <= 1'b0;
            end else if (s_accept) begin
                load_cnt <= load_cnt + 1'b1;
            end
            if (start_accept) a_cnt <= '0;
            else if (a_accept) a_cnt <= a_cnt + 1'b1;
            if (state == ST_DRAIN) sneg <= ~sneg;
            if (s1_valid && (|lane_bad)) err <= 1'b1;
        end
    end

    // Loading and rotation share the same shift; rotation negates the wrapped tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) sreg[k] <= '0;
        end else if (s_accept) begin
            for (int k = N - 1; k > 0; k--) sreg[k] <= sreg[k-1];
            sreg[0] <= sec_canon(s_data);
        end else if (a_accept) begin
            for (int k = N - 1; k > 0; k--) sreg[k] <= sreg[k-1];
            sreg[0] <= sec_neg(sreg[N-1]);
        end
    end

    always_comb begin
        ax_next[1] = a_data;
        ax_next[2] = a_data << 1;
        ax_next[3] = a_data + (a_data << 1);
        ax_next[4] = a_data << 2;
`ifdef SABER_LIGHTSABER_EN
        ax_next[5] = a_data + (a_data << 2);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sneg  <= 1'b0;
            ax_q     <= '0;
            for (int l = 0; l < NUM_MAC; l++) tap_q[l] <= '0;
        end else begin
            s1_valid <= a_accept;
            if (a_accept) begin
                s1_sneg <= sneg;
                ax_q    <= ax_next;
                for (int l = 0; l < NUM_MAC; l++) tap_q[l] <= sreg[l];
            end
        end
    end

    for (genvar l = 0; l < NUM_MAC; l++) begin : g_lane
        saber_mac_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (lane_clear),
            .en     (s1_valid),
            .ax_mul (ax_q),
            .tap    (tap_q[l]),
            .sneg   (s1_sneg),
            .acc    (lane_acc[l]),
            .bad    (lane_bad[l])
        );
        assign result[l*LANE_W +: LANE_W] = {{(LANE_W - Q_W){1'b0}}, lane_acc[l]};
    end

endmodule
